// File: rtl/branch_resolver.sv
// Decode-stage branch / jump-register resolver: waits out EX/MEM operand hazards,
// evaluates the condition and emits one-cycle redirect pulses plus saturating branch statistics.
module branch_resolver #(
    parameter int          MAX_WAIT = 2,
    parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InstrValid,
    input  logic [31:0] InstrID,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic [4:0]  ExWriteReg,
    input  logic        ExRegWrite,
    input  logic [4:0]  MemWriteReg,
    input  logic        MemRegWrite,
    output logic        branch,
    output logic [15:0] branchAmount,
    output logic        jumpRegister,
    output logic [31:0] Register,
    output logic        busy,
    output logic [15:0] BranchCount,
    output logic [15:0] TakenCount
);
    localparam int CW = $clog2(MAX_WAIT + 2);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [5:0]     op_q, op_d;
    logic [4:0]     rs_q, rs_d;
    logic [4:0]     rt_q, rt_d;
    logic [15:0]    offset_q, offset_d;
    logic           branch_q, branch_d;
    logic           jr_q, jr_d;
    logic [15:0]    amount_q, amount_d;
    logic [31:0]    register_q, register_d;
    logic [15:0]    bcnt_q, bcnt_d;
    logic [15:0]    tcnt_q, tcnt_d;

    function automatic logic is_hazard(input logic [4:0] r,
                                       input logic [4:0] ex_reg, input logic ex_we,
                                       input logic [4:0] mem_reg, input logic mem_we);
        return (r != 5'd0) && ((ex_we && (r == ex_reg)) || (mem_we && (r == mem_reg)));
    endfunction

    logic [5:0] in_op;
    logic [4:0] in_rs, in_rt;
    logic       in_branch, in_jr, in_uses_rt, in_hazard;
    logic       lat_uses_rt, lat_hazard, taken;
    logic [CW-1:0] wait_inc;

    assign in_op      = InstrID[31:26];
    assign in_rs      = InstrID[25:21];
    assign in_rt      = InstrID[20:16];
    assign in_uses_rt = (in_op == OP_BEQ) || (in_op == OP_BNE);
    assign in_jr      = (in_op == OP_SPECIAL) && (InstrID[5:0] == FN_JR);
    assign in_branch  = in_uses_rt
                     || ((in_op == OP_REGIMM) && ((in_rt == 5'd0) || (in_rt == 5'd1)))
                     || (((in_op == OP_BLEZ) || (in_op == OP_BGTZ)) && (in_rt == 5'd0));
    assign in_hazard  = is_hazard(in_rs, ExWriteReg, ExRegWrite, MemWriteReg, MemRegWrite)
                     || (in_uses_rt && is_hazard(in_rt, ExWriteReg, ExRegWrite, MemWriteReg, MemRegWrite));

    assign lat_uses_rt = (op_q == OP_BEQ) || (op_q == OP_BNE);
    assign lat_hazard  = is_hazard(rs_q, ExWriteReg, ExRegWrite, MemWriteReg, MemRegWrite)
                      || (lat_uses_rt && is_hazard(rt_q, ExWriteReg, ExRegWrite, MemWriteReg, MemRegWrite));
    assign wait_inc    = wait_cnt_q + CW'(1);

    // Only REGIMM rt=0/1 is ever latched, so rt_q alone selects BLTZ vs BGEZ.
    always_comb begin
        taken = 1'b0;
        case (op_q)
            OP_BEQ:    taken = (RsData == RtData);
            OP_BNE:    taken = (RsData != RtData);
            OP_REGIMM: taken = (rt_q == 5'd0) ? ($signed(RsData) < 0) : ($signed(RsData) >= 0);
            OP_BLEZ:   taken = ($signed(RsData) <= 0);
            OP_BGTZ:   taken = ($signed(RsData) > 0);
            default:   taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        op_d       = op_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        offset_d   = offset_q;
        branch_d   = 1'b0;
        jr_d       = 1'b0;
        amount_d   = amount_q;
        register_d = register_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (InstrValid && (in_branch || in_jr)) begin
                    op_d       = in_op;
                    rs_d       = in_rs;
                    rt_d       = in_rt;
                    offset_d   = InstrID[15:0];
                    wait_cnt_d = '0;
                    state_d    = in_hazard ? S_WAIT : S_RESOLVE;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_inc;
                if (!lat_hazard || (wait_inc >= CW'(MAX_WAIT)))
                    state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
                if (op_q == OP_SPECIAL) begin
                    jr_d       = 1'b1;
                    register_d = RsData;
                end else begin
                    if (bcnt_q != CNT_MAX)
                        bcnt_d = bcnt_q + 16'd1;
                    if (taken) begin
                        branch_d = 1'b1;
                        amount_d = offset_q;
                        if (tcnt_q != CNT_MAX)
                            tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            offset_q   <= '0;
            branch_q   <= 1'b0;
            jr_q       <= 1'b0;
            amount_q   <= '0;
            register_q <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            offset_q   <= offset_d;
            branch_q   <= branch_d;
            jr_q       <= jr_d;
            amount_q   <= amount_d;
            register_q <= register_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign branch       = branch_q;
    assign branchAmount = amount_q;
    assign jumpRegister = jr_q;
    assign Register     = register_q;
    assign busy         = (state_q != S_IDLE);
    assign BranchCount  = bcnt_q;
    assign TakenCount   = tcnt_q;
endmodule
